// File: rtl/wsg_pkg.sv
// Shared types and constants for the parametrised waveform sound generator.
// Register offsets are relative to the window base; each voice occupies a 5-byte stride.
package wsg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_MAC,
    ST_OUT
  } wsg_state_t;

  localparam logic [7:0] WAVE_OFS     = 8'h05;
  localparam logic [7:0] FREQ_OFS     = 8'h10;
  localparam logic [7:0] VOL_OFS      = 8'h15;
  localparam int         VOICE_STRIDE = 5;

  localparam int WAVE_IDX_W  = 3;
  localparam int SAMPLE_W    = 4;
  localparam int VOL_W       = 4;
  localparam int PHASE_IDX_W = 5;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [7:0] ofs,
                                           input int voice, input int nib);
    return base + 16'(ofs) + 16'(VOICE_STRIDE * voice + nib);
  endfunction

endpackage

// File: rtl/wsg_reg_file.sv
// CPU-writable per-voice wave index, frequency and volume registers.
// Voices above 0 have no frequency nibble 0; that address belongs to the previous voice's volume.
module wsg_reg_file
  import wsg_pkg::*;
#(
  parameter int          NUM_VOICES = 3,
  parameter int          ACC_W      = 20,
  parameter logic [15:0] ADDR_BASE  = 16'h5040
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [15:0]           ram_addr,
  input  logic [7:0]            cpu_data,
  output logic [WAVE_IDX_W-1:0] wave_q [NUM_VOICES],
  output logic [ACC_W-1:0]      freq_q [NUM_VOICES],
  output logic [VOL_W-1:0]      vol_q  [NUM_VOICES]
);

  logic [WAVE_IDX_W-1:0] wave_d [NUM_VOICES];
  logic [ACC_W-1:0]      freq_d [NUM_VOICES];
  logic [VOL_W-1:0]      vol_d  [NUM_VOICES];
  logic                  cpu_data_unused;

  assign cpu_data_unused = ^cpu_data[7:4];

  always_comb begin
    wave_d = wave_q;
    freq_d = freq_q;
    vol_d  = vol_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (wr_en && ram_addr == reg_addr(ADDR_BASE, WAVE_OFS, v, 0))
        wave_d[v] = cpu_data[WAVE_IDX_W-1:0];
      if (wr_en && ram_addr == reg_addr(ADDR_BASE, VOL_OFS, v, 0))
        vol_d[v] = cpu_data[VOL_W-1:0];
      for (int n = 0; n < ACC_W / 4; n++) begin
        if (wr_en && (v == 0 || n != 0) && ram_addr == reg_addr(ADDR_BASE, FREQ_OFS, v, n))
          freq_d[v][4*n +: 4] = cpu_data[3:0];
      end
      if (v != 0)
        freq_d[v][3:0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        wave_q[v] <= '0;
        freq_q[v] <= '0;
        vol_q[v]  <= '0;
      end
    end else begin
      wave_q <= wave_d;
      freq_q <= freq_d;
      vol_q  <= vol_d;
    end
  end

endmodule

// File: rtl/wsg_mixer.sv
// Multi-voice wavetable mixer: sample-rate divider, phase accumulators, shared-ROM sequencer and MAC.
// Define WSG_SATURATE_EN to clamp the mix at 255 instead of wrapping it like the legacy mixer.
module wsg_mixer
  import wsg_pkg::*;
#(
  parameter int          NUM_VOICES = 3,
  parameter int          ACC_W      = 20,
  parameter int          RATE_DIV   = 1042,
  parameter int          OUT_W      = 10,
  parameter logic [15:0] ADDR_BASE  = 16'h5040
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [15:0]      ram_addr,
  input  logic [7:0]       cpu_data,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             overrun
);

  localparam int MIX_W = 8 + $clog2(NUM_VOICES + 1);
  localparam int CNT_W = $clog2(RATE_DIV);
  localparam int V_W   = 2;

  logic [WAVE_IDX_W-1:0] wave_q [NUM_VOICES];
  logic [ACC_W-1:0]      freq_q [NUM_VOICES];
  logic [VOL_W-1:0]      vol_q  [NUM_VOICES];

  wsg_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [ACC_W-1:0]  acc_q [NUM_VOICES];
  logic [ACC_W-1:0]  acc_d [NUM_VOICES];
  logic [MIX_W-1:0]  mix_q, mix_d;
  logic [7:0]        rom_addr_q, rom_addr_d;
  logic [OUT_W-1:0]  sample_out_q, sample_out_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;

  logic                  tick;
  logic [WAVE_IDX_W-1:0] cur_wave;
  logic [ACC_W-1:0]      cur_acc;
  logic [VOL_W-1:0]      cur_vol;
  logic [7:0]            product;
  logic [7:0]            mix8;
  logic                  rom_data_unused;

  wsg_reg_file #(
    .NUM_VOICES (NUM_VOICES),
    .ACC_W      (ACC_W),
    .ADDR_BASE  (ADDR_BASE)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .ram_addr (ram_addr),
    .cpu_data (cpu_data),
    .wave_q   (wave_q),
    .freq_q   (freq_q),
    .vol_q    (vol_q)
  );

  assign rom_data_unused = ^rom_data[7:SAMPLE_W];
  assign tick            = (cnt_q == CNT_W'(RATE_DIV - 1));
  assign cnt_d           = tick ? '0 : cnt_q + CNT_W'(1);
  assign product         = {4'b0, rom_data[SAMPLE_W-1:0]} * {4'b0, cur_vol};

`ifdef WSG_SATURATE_EN
  assign mix8 = (mix_q > MIX_W'(255)) ? 8'hFF : mix_q[7:0];
`else
  assign mix8 = mix_q[7:0];
`endif

  always_comb begin
    cur_wave = '0;
    cur_acc  = '0;
    cur_vol  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (v_q == V_W'(v)) begin
        cur_wave = wave_q[v];
        cur_acc  = acc_q[v];
        cur_vol  = vol_q[v];
      end
    end
  end

  // One voice per ADDR/WAIT/MAC triple; the ROM address is registered so data lands in MAC.
  always_comb begin
    state_d        = state_q;
    v_d            = v_q;
    acc_d          = acc_q;
    mix_d          = mix_q;
    rom_addr_d     = rom_addr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q | (tick && state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          mix_d   = '0;
          v_d     = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        rom_addr_d = {cur_wave, cur_acc[ACC_W-1 -: PHASE_IDX_W]};
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (v_q == V_W'(v))
            acc_d[v] = acc_q[v] + freq_q[v];
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: state_d = ST_MAC;
      ST_MAC: begin
        mix_d = mix_q + MIX_W'(product);
        if (v_q == V_W'(NUM_VOICES - 1)) begin
          state_d = ST_OUT;
        end else begin
          v_d     = v_q + V_W'(1);
          state_d = ST_ADDR;
        end
      end
      ST_OUT: begin
        sample_out_d   = OUT_W'(mix8) << (OUT_W - 8);
        sample_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      v_q            <= '0;
      mix_q          <= '0;
      rom_addr_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++)
        acc_q[v] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      v_q            <= v_d;
      mix_q          <= mix_d;
      rom_addr_q     <= rom_addr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      acc_q          <= acc_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule
